gpio_port: RTL and testbench

- Parametrised general-purpose I/O port. Successor to the fixed 8-bit output-only register.
- Adds:
  - configurable width
  - per-pin direction (output-enable)
  - atomic set/clear/toggle writes
  - synchronised pin input with readback
  - sticky rising-edge flags with a level interrupt
- Sits on the CPU I/O bus behind a Decoupled command channel and a Decoupled response channel.

---
 rtl/gpio_port_if.sv | 15 +
 rtl/gpio_port.sv | 147 ++++++++++++++
 tb/tb_gpio_port.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_port_if.sv
// Decoupled valid/ready channel carrying a W-bit payload.
//   valid  producer -> consumer  payload is present
//   ready  consumer -> producer  payload can be taken this cycle
//   bits   producer -> consumer  payload
// A transfer happens on any clock edge where valid && ready.
interface gpio_port_if #(
   parameter int W = 8
);
   logic         valid;
   logic         ready;
   logic [W-1:0] bits;

   modport master (output valid, output bits, input ready);
   modport slave  (input valid, input bits, output ready);
endinterface

// File: rtl/gpio_port.sv
// Parametrised general-purpose I/O port on a decoupled command/response bus.
// Commands (if_din) update the output/direction registers atomically or
// request a readback; readbacks are returned on if_dout one cycle after
// accept. Pin inputs are synchronised, and rising edges set sticky flags
// whose OR drives a registered level interrupt.
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   if_din   command channel, bits = {opcode[2:0], data[WIDTH-1:0]}
//   if_dout  response channel, bits = WIDTH-bit read data
//   i_gpin   raw asynchronous pin inputs
//   o_gpout  output register
//   o_gpoe   direction register (1 = drive pin)
//   o_irq    OR of sticky rising-edge flags, registered
module gpio_port #(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_OUT   = '0,
   parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   gpio_port_if.slave       if_din,
   gpio_port_if.master      if_dout,
   input  logic [WIDTH-1:0] i_gpin,
   output logic [WIDTH-1:0] o_gpout,
   output logic [WIDTH-1:0] o_gpoe,
   output logic             o_irq
);

   typedef enum logic [2:0] {
      OP_WRITE         = 3'd0,
      OP_SET           = 3'd1,
      OP_CLEAR         = 3'd2,
      OP_TOGGLE        = 3'd3,
      OP_WRITE_DIR     = 3'd4,
      OP_READ_PINS     = 3'd5,
      OP_READ_OUT      = 3'd6,
      OP_READ_CLR_EDGE = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE,
      ST_RESP
   } state_e;

   state_e state, state_nxt;

   logic [WIDTH-1:0] out_q, out_nxt;
   logic [WIDTH-1:0] dir_q, dir_nxt;
   logic [WIDTH-1:0] resp_q, resp_nxt;
   logic [WIDTH-1:0] edge_q;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] prev_q;
   logic             irq_q;

   // Element [0] takes the raw pins; element [SYNC_STAGES-1] is the
   // synchronised value.
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] rise;
   op_e              op;
   logic [WIDTH-1:0] data;
   logic             accept;

   assign op      = op_e'(if_din.bits[WIDTH+2:WIDTH]);
   assign data    = if_din.bits[WIDTH-1:0];
   assign accept  = if_din.valid && if_din.ready;
   assign sync_in = sync_q[SYNC_STAGES-1];
   assign rise    = sync_in & ~prev_q;

   // A held response can be replaced in the same cycle it is consumed, so
   // reads stream back-to-back without a bubble.
   assign if_din.ready  = (state == ST_IDLE) || if_dout.ready;
   assign if_dout.valid = (state == ST_RESP);
   assign if_dout.bits  = resp_q;

   assign o_gpout = out_q;
   assign o_gpoe  = dir_q;
   assign o_irq   = irq_q;

   // Next-state and register-update logic.
   // NOTE: every signal gets a default before any branch, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      out_nxt   = out_q;
      dir_nxt   = dir_q;
      resp_nxt  = resp_q;
      clr       = '0;

      if ((state == ST_RESP) && if_dout.ready) begin
         state_nxt = ST_IDLE;
      end

      if (accept) begin
         case (op)
            OP_WRITE:     out_nxt = data;
            OP_SET:       out_nxt = out_q | data;
            OP_CLEAR:     out_nxt = out_q & ~data;
            OP_TOGGLE:    out_nxt = out_q ^ data;
            OP_WRITE_DIR: dir_nxt = data;
            OP_READ_PINS: begin
               resp_nxt  = (dir_q & out_q) | (~dir_q & sync_in);
               state_nxt = ST_RESP;
            end
            OP_READ_OUT: begin
               resp_nxt  = out_q;
               state_nxt = ST_RESP;
            end
            OP_READ_CLR_EDGE: begin
               resp_nxt  = edge_q;
               // Only flags actually reported can be cleared.
               clr       = data & edge_q;
               state_nxt = ST_RESP;
            end
         endcase
      end
   end

   // NOTE: all state uses non-blocking assignments so every flop samples the
   // pre-edge value of its neighbours; blocking here would collapse the
   // synchroniser chain into a single stage.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= ST_IDLE;
         out_q  <= RESET_OUT;
         dir_q  <= RESET_DIR;
         resp_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
         edge_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         out_q  <= out_nxt;
         dir_q  <= dir_nxt;
         resp_q <= resp_nxt;
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_gpin};
         prev_q <= sync_in;
         // A rise coinciding with a clear of the same bit keeps the flag.
         edge_q <= (edge_q & ~clr) | rise;
         irq_q  <= |edge_q;
      end
   end

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port (WIDTH=8, SYNC_STAGES=2,
// RESET_OUT=8'hA5, RESET_DIR=8'h0F). Stimulus pushes expected read data
// into a scoreboard queue; a monitor pops and compares on every response
// handshake. Level checks on pins and irq are made directly.
module tb_gpio_port;
   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] gpin;
   logic [W-1:0] gpout;
   logic [W-1:0] gpoe;
   logic         irq;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] sb[$];

   gpio_port_if #(.W(W+3)) din_if ();
   gpio_port_if #(.W(W))   dout_if ();

   gpio_port #(
      .WIDTH      (W),
      .SYNC_STAGES(2),
      .RESET_OUT  (8'hA5),
      .RESET_DIR  (8'h0F)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .if_din (din_if),
      .if_dout(dout_if),
      .i_gpin (gpin),
      .o_gpout(gpout),
      .o_gpoe (gpoe),
      .o_irq  (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Present a command and hold it until accepted; returns 1 ns after the
   // accepting edge.
   task automatic send(input logic [2:0] op, input logic [W-1:0] d);
      int n;
      n = 0;
      din_if.valid = 1'b1;
      din_if.bits  = {op, d};
      @(negedge clk);
      while (!din_if.ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!din_if.ready) begin
         check("din_ready_timeout", 32'd0, 32'd1);
      end
      @(posedge clk);
      #1;
      din_if.valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Response monitor: handshake decided on the next rising edge.
   initial begin
      logic [W-1:0] exp;
      forever begin
         @(negedge clk);
         if (rst_n && dout_if.valid && dout_if.ready) begin
            if (sb.size() == 0) begin
               check("unexpected_resp", {24'd0, dout_if.bits}, 32'hFFFF_FFFF);
            end else begin
               exp = sb.pop_front();
               check("resp_bits", {24'd0, dout_if.bits}, {24'd0, exp});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      din_if.valid  = 1'b0;
      din_if.bits   = '0;
      dout_if.ready = 1'b1;
      gpin          = '0;
      #22;
      rst_n = 1'b1;
      cycles(1);

      // Reset values
      check("rst_gpout", {24'd0, gpout}, 32'hA5);
      check("rst_gpoe", {24'd0, gpoe}, 32'h0F);
      check("rst_valid", {31'd0, dout_if.valid}, 32'd0);
      check("rst_bits", {24'd0, dout_if.bits}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_ready", {31'd0, din_if.ready}, 32'd1);

      // Atomic output updates, back-to-back
      send(3'd0, 8'h3C);
      check("write_out", {24'd0, gpout}, 32'h3C);
      send(3'd1, 8'h01);
      check("set_out", {24'd0, gpout}, 32'h3D);
      send(3'd2, 8'h0C);
      check("clear_out", {24'd0, gpout}, 32'h31);
      send(3'd3, 8'hFF);
      check("toggle_out", {24'd0, gpout}, 32'hCE);
      check("no_resp_wr", {31'd0, dout_if.valid}, 32'd0);
      check("dir_kept", {24'd0, gpoe}, 32'h0F);

      // Pin readback mixes driven and sampled bits
      send(3'd4, 8'hF0);
      check("write_dir", {24'd0, gpoe}, 32'hF0);
      send(3'd0, 8'hAA);
      gpin = 8'h55;
      cycles(3);
      sb.push_back(8'hA5);
      send(3'd5, 8'h00);
      check("rdpins_valid", {31'd0, dout_if.valid}, 32'd1);
      check("rdpins_bits", {24'd0, dout_if.bits}, 32'hA5);
      cycles(1);
      check("rdpins_done", {31'd0, dout_if.valid}, 32'd0);

      // Backpressure then back-to-back read
      dout_if.ready = 1'b0;
      sb.push_back(8'hAA);
      send(3'd6, 8'h00);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", {31'd0, dout_if.valid}, 32'd1);
         check("stall_bits", {24'd0, dout_if.bits}, 32'hAA);
         check("stall_din_ready", {31'd0, din_if.ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      dout_if.ready = 1'b1;
      sb.push_back(8'hA5);
      send(3'd5, 8'h00);
      check("b2b_valid", {31'd0, dout_if.valid}, 32'd1);
      check("b2b_bits", {24'd0, dout_if.bits}, 32'hA5);
      cycles(1);
      check("b2b_done", {31'd0, dout_if.valid}, 32'd0);

      // Flush flags from the 00->55 pin change, then single edge on bit3
      check("irq_pre", {31'd0, irq}, 32'd1);
      sb.push_back(8'h55);
      send(3'd7, 8'hFF);
      cycles(2);
      check("irq_flushed", {31'd0, irq}, 32'd0);
      gpin = 8'h5D;
      cycles(3);
      check("irq_early", {31'd0, irq}, 32'd0);
      cycles(1);
      check("irq_bit3", {31'd0, irq}, 32'd1);
      sb.push_back(8'h08);
      send(3'd7, 8'hFF);
      check("irq_hold", {31'd0, irq}, 32'd1);
      cycles(1);
      check("irq_cleared", {31'd0, irq}, 32'd0);

      // Set wins: a bit0 rise lands in the cycle its flag is being cleared
      gpin = 8'h5C;
      cycles(4);
      gpin = 8'h5D;
      cycles(5);
      check("irq_bit0", {31'd0, irq}, 32'd1);
      gpin = 8'h5C;
      cycles(4);
      gpin = 8'h5D;
      cycles(2);
      sb.push_back(8'h01);
      send(3'd7, 8'hFF);
      check("setwin_irq0", {31'd0, irq}, 32'd1);
      cycles(2);
      check("setwin_irq2", {31'd0, irq}, 32'd1);
      sb.push_back(8'h01);
      send(3'd7, 8'hFF);
      cycles(1);
      check("setwin_final", {31'd0, irq}, 32'd0);

      // Asynchronous reset drops a pending response
      dout_if.ready = 1'b0;
      sb.push_back(8'hAA);
      send(3'd6, 8'h00);
      check("pend_valid", {31'd0, dout_if.valid}, 32'd1);
      sb.delete();
      #2;
      rst_n = 1'b0;
      gpin  = '0;
      #1;
      check("arst_valid", {31'd0, dout_if.valid}, 32'd0);
      check("arst_gpout", {24'd0, gpout}, 32'hA5);
      check("arst_gpoe", {24'd0, gpoe}, 32'h0F);
      check("arst_bits", {24'd0, dout_if.bits}, 32'd0);
      check("arst_ready", {31'd0, din_if.ready}, 32'd1);
      cycles(2);
      #2;
      rst_n         = 1'b1;
      dout_if.ready = 1'b1;
      cycles(5);
      check("post_valid", {31'd0, dout_if.valid}, 32'd0);
      check("post_gpout", {24'd0, gpout}, 32'hA5);
      check("post_irq", {31'd0, irq}, 32'd0);
      check("sb_empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
